// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Each operation takes 32 single-bit shift-add or restoring shift-subtract steps.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r;
    logic [5:0]  count_r;
    logic        is_div_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic [31:0] acc_hi_r;
    logic [31:0] acc_lo_r;
    logic [31:0] m_r;
    logic [31:0] a_raw_r;

    logic        signed_op_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_tmp_s;
    logic [31:0] div_diff_s;
    logic        div_ge_s;
    logic [31:0] next_hi_s;
    logic [31:0] next_lo_s;
    logic [63:0] prod_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        if (neg) begin
            magnitude = 32'd0 - v;
        end else begin
            magnitude = v;
        end
    endfunction

    // Operand magnitudes and one iteration step of the multiply or divide datapath.
    always_comb begin
        signed_op_s = ~op[0];
        mag_a_s     = magnitude(operand_a, signed_op_s & operand_a[31]);
        mag_b_s     = magnitude(operand_b, signed_op_s & operand_b[31]);

        if (acc_lo_r[0]) begin
            mul_sum_s = {1'b0, acc_hi_r} + {1'b0, m_r};
        end else begin
            mul_sum_s = {1'b0, acc_hi_r};
        end

        div_tmp_s  = {acc_hi_r, acc_lo_r[31]};
        div_ge_s   = (div_tmp_s >= {1'b0, m_r});
        div_diff_s = div_tmp_s[31:0] - m_r;

        if (is_div_r) begin
            if (div_ge_s) begin
                next_hi_s = div_diff_s;
            end else begin
                next_hi_s = div_tmp_s[31:0];
            end
            next_lo_s = {acc_lo_r[30:0], div_ge_s};
        end else begin
            next_hi_s = mul_sum_s[32:1];
            next_lo_s = {mul_sum_s[0], acc_lo_r[31:1]};
        end
    end

    // Sign correction of the final step; divide-by-zero bypasses the datapath result.
    always_comb begin
        prod_s = {next_hi_s, next_lo_s};
        if (!is_div_r) begin
            if (neg_q_r) begin
                prod_s = 64'd0 - prod_s;
            end else begin
                prod_s = prod_s;
            end
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end else if (m_r == 32'd0) begin
            res_hi_s = a_raw_r;
            res_lo_s = 32'hFFFF_FFFF;
        end else begin
            res_hi_s = magnitude(next_hi_s, neg_r_r);
            res_lo_s = magnitude(next_lo_s, neg_q_r);
        end
    end

    // Control FSM, iteration datapath registers and architectural HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            count_r  <= 6'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= 32'h0;
            lo       <= 32'h0;
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            acc_hi_r <= 32'h0;
            acc_lo_r <= 32'h0;
            m_r      <= 32'h0;
            a_raw_r  <= 32'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (hi_we) begin
                        hi <= write_data;
                    end
                    if (lo_we) begin
                        lo <= write_data;
                    end
                    if (start) begin
                        state_r  <= RUN;
                        busy     <= 1'b1;
                        count_r  <= 6'd0;
                        is_div_r <= op[1];
                        neg_q_r  <= ~op[0] & (operand_a[31] ^ operand_b[31]);
                        neg_r_r  <= ~op[0] & operand_a[31];
                        acc_hi_r <= 32'h0;
                        acc_lo_r <= op[1] ? mag_a_s : mag_b_s;
                        m_r      <= op[1] ? mag_b_s : mag_a_s;
                        a_raw_r  <= operand_a;
                    end
                end
                RUN: begin
                    acc_hi_r <= next_hi_s;
                    acc_lo_r <= next_lo_s;
                    count_r  <= count_r + 6'd1;
                    if (count_r == 6'd31) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        hi      <= res_hi_s;
                        lo      <= res_lo_s;
                    end else begin
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; the datapath width is fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high; clears all state.
REQ-004 start  in  1  request a new operation; accepted only when busy=0.
REQ-005 op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 operand_a  in  32  rs value from register-file port A (dividend / multiplicand).
REQ-007 operand_b  in  32  rt value from register-file port B (divisor / multiplier).
REQ-008 hi_we  in  1  MTHI: write write_data into HI.
REQ-009 lo_we  in  1  MTLO: write write_data into LO.
REQ-010 write_data  in  32  data for MTHI/MTLO.
REQ-011 busy  out  1  operation in progress.
REQ-012 done  out  1  one-cycle pulse; HI/LO hold the new result.
REQ-013 hi  out  32  HI register (MFHI source).
REQ-014 lo  out  32  LO register (MFLO source).

Function
REQ-015 The unit SHALL implement two states, IDLE (busy=0) and RUN (busy=1), plus a 6-bit iteration counter.
REQ-016 At a rising edge with state IDLE and start=1, the unit SHALL latch op, operand_a and operand_b, enter RUN and load counter=0.
- Operand changes after that edge are ignored.
REQ-017 RUN SHALL last exactly 32 cycles, performing one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle.
REQ-018 Latency: for a start accepted at edge T0:
- busy=1 from T0 until T32;
- HI/LO update at T32;
- busy=0 and done=1 during the cycle following T32;
- done=0 otherwise.
REQ-019 Signed ops (MULT, DIV) SHALL operate on magnitudes and apply the sign correction in the final step; results become visible only at T32.
REQ-020 MULT/MULTU SHALL produce the full 64-bit product, {hi,lo} = product.
REQ-021 DIV/DIVU SHALL set lo = quotient truncated toward zero and hi = remainder; the remainder takes the sign of the dividend.
REQ-022 Divide by zero (operand_b=0, DIV or DIVU) SHALL complete normally in 32 cycles with lo=32'hFFFFFFFF and hi=operand_a, raising no error.
REQ-023 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=32'h00000000.
REQ-024 start=1 while busy=1 SHALL be ignored.
- No queuing.
- The in-flight operation is unaffected.
REQ-025 hi_we/lo_we in IDLE SHALL update HI/LO at the edge; hi_we/lo_we while busy=1 SHALL be dropped.
REQ-026 Simultaneous start and hi_we/lo_we in IDLE:
- the write SHALL apply at that edge;
- the operation's result SHALL overwrite HI/LO at T32.
REQ-027 hi/lo SHALL hold their previous values throughout RUN, so MFHI/MFLO return the old contents until done.
REQ-028 A start accepted in the done cycle SHALL begin a new operation with no idle gap.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force:
- state=IDLE, counter=0;
- busy=0, done=0;
- hi=32'h0, lo=32'h0.
REQ-030 rst asserted mid-operation SHALL abort the operation; no result is written after rst deasserts.
REQ-031 While rst=1, start/hi_we/lo_we SHALL be ignored; the first start is accepted at the first rising edge with rst=0.

Verification
REQ-032 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> busy high for 32 cycles, then done pulse, hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-033 MULT -3 x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; hi/lo unchanged before done.
REQ-034 DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
REQ-035 DIVU 5 / 0 -> after 32 cycles lo=32'hFFFFFFFF, hi=32'h00000005; DIV 5 / 0 gives the same result.
REQ-036 Start DIVU 100/7, then hi_we=1 and start=1 (with new operands) mid-RUN -> both ignored; final lo=14, hi=2.
REQ-037 Start MULTU, assert rst at cycle 10 (asynchronously) -> busy/done/hi/lo go to 0 at once; after release, MTLO 32'h1234 sets lo=32'h1234 and a new MULTU 3x4 gives lo=12, hi=0.
